alu_sweep_seq: RTL and testbench
================================

# alu_sweep_seq

Operand/opcode sequencer that drives the 4-bit ALU datapath and consumes its registered 8-bit result. It is the initiator end of the ALU interface. On `start` it sweeps every (a, b) pair for each opcode enabled in a mask, issuing one vector per cycle, pipelined. It captures each result a fixed latency later and folds it into a checksum and vector count, so an on-chip sweep can be read back through the top-level pins.

## Interface
Parameters:
- `LATENCY`, 2: cycles from driving `op_*` to the matching `result` being valid. Range 1..4.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request a sweep; sampled only in IDLE.
- `sel_mask` in 8: bit n enables opcode n; sampled when `start` is accepted.
- `result` in 8: registered ALU output.
- `op_a` out 4: operand a driven to the ALU.
- `op_b` out 4: operand b driven to the ALU.
- `op_sel` out 3: opcode driven to the ALU.
- `busy` out 1: high while in ISSUE or DRAIN.
- `done` out 1: one-cycle pulse at sweep end.
- `checksum` out 16: running signature of captured results.
- `count` out 12: number of results captured.
- `err_cnt` out 8: mismatch count; functional only with the macro.
- `fail_vec` out 11: {sel,a,b} of the first mismatch; functional only with the macro.

## Operation
- FSM states and transitions:
  - IDLE: waits for `start`.
  - ISSUE: drives vectors.
  - DRAIN: waits out the pipeline.
  - DONE: lasts one cycle, then returns to IDLE.
- Start acceptance:
  - In IDLE with `start`=1: latch `sel_mask`, clear `checksum`, `count`, `err_cnt` and `fail_vec`, then go to ISSUE.
  - If the latched mask is 0, go directly to DONE.
- Vector order: ascending enabled opcode, then `a` 0..15 (outer), then `b` 0..15 (inner). That gives 256 vectors per enabled opcode.
- ISSUE drives one vector per cycle. After the last vector of the last enabled opcode, go to DRAIN.
- Capture pipeline:
  - A valid/tag shift register of depth `LATENCY` tracks issued vectors.
  - When its tail is valid, `result` is sampled:
    - `checksum <= {checksum[14:0],checksum[15]} ^ {8'h00,result}`
    - `count <= count+1`
- DRAIN lasts exactly `LATENCY` cycles, then goes to DONE.
- `op_*` hold 0 in IDLE, DRAIN and DONE.
- `checksum`, `count`, `err_cnt` and `fail_vec` hold their values after DONE until the next accepted `start`.
- `start` during ISSUE, DRAIN or DONE is ignored.
- `count` maximum is 2048; 12 bits gives no wrap.
- Reset: `rst` asynchronously forces IDLE and zeroes every output, including while mid-sweep.

## Timing
- Label the cycle after the edge that accepts `start` as cycle 1.
- For N enabled opcodes:
  - ISSUE occupies cycles 1..256N.
  - DRAIN occupies the next `LATENCY` cycles.
  - `done`=1 in cycle 256N+`LATENCY`+1, with `busy`=0 in that cycle.
- `busy` is high in cycles 1..256N+`LATENCY`.
- A vector driven in cycle k has its result sampled at the end of cycle k+`LATENCY`.
- `count` and `checksum` update at that same edge.
- Mask 0: `done`=1 in cycle 1, `busy` stays 0, `count` reads 0.
- All outputs are registered.

## Configuration
- `ALU_SWEEP_CHECK_EN` defined:
  - An inline golden model computes the expected result for each tagged vector:
    - add: `a+b` zero-extended
    - sub: `a-b` mod 256
    - and / or / xor: zero-extended
    - not: `{~b,~a}`
    - mul: `a*b`
    - div: `a/b`, or 0 when b=0
  - Each mismatch increments `err_cnt`, saturating at 255.
  - The first mismatch of the sweep loads `fail_vec`.
- `ALU_SWEEP_CHECK_EN` undefined:
  - No model logic is built.
  - `err_cnt` and `fail_vec` are tied to 0.

## Test plan
- `sel_mask`=8'h01, correct 2-cycle ALU model -> `done` in cycle 259; `count`=256; `busy` high in cycles 1..258; with the macro, `err_cnt`=0.
- `sel_mask`=8'h00 -> `done` in cycle 1, `count`=0, `checksum`=16'h0000, no `op_*` activity.
- `sel_mask`=8'h80, `result` forced to 8'h00, macro on -> `count`=256, `err_cnt`=120, `fail_vec`={3'b111,4'd1,4'd1}, `checksum`=16'h0000.
- `sel_mask`=8'hFF, correct model -> `done` in cycle 2051, `count`=2048, `err_cnt`=0. `op_sel` steps 0..7 at cycles 1, 257, …, 1793.
- Sweep with `sel_mask`=8'h01; pulse `start` again in cycle 10 -> ignored; `count` still ends at 256 and `done` still occurs in cycle 259.
- Assert `rst` during ISSUE cycle 100 -> in the same cycle `busy`=0, `op_*`=0, `count`=0, `checksum`=0. A new `start` after release runs a full sweep.

Source files
------------

// File: rtl/alu_sweep_seq.sv
// alu_sweep_seq: operand/opcode sequencer for the 4-bit ALU datapath.
// On start it sweeps every (a, b) pair for each opcode enabled in sel_mask,
// one vector per cycle. Each result is captured LATENCY cycles later and
// folded into a rotating checksum and a vector count.
// Optional feature: define ALU_SWEEP_CHECK_EN to build an inline golden
// model that counts mismatches (err_cnt) and records the first failing
// vector (fail_vec). Without the macro both outputs are tied to 0.
module alu_sweep_seq #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  sel_mask,
  input  logic [7:0]  result,
  output logic [3:0]  op_a,
  output logic [3:0]  op_b,
  output logic [2:0]  op_sel,
  output logic        busy,
  output logic        done,
  output logic [15:0] checksum,
  output logic [11:0] count,
  output logic [7:0]  err_cnt,
  output logic [10:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t             state;
  logic [7:0]         mask;
  logic [2:0]         drain_cnt;
  logic [LATENCY-1:0] pipe_vld;

  logic [2:0] first_sel;
  logic       first_any;
  logic [2:0] next_sel;
  logic       next_any;
  logic       accept;

  assign accept = (state == IDLE) && start;

  // Lowest enabled opcode in the incoming mask, and the next enabled opcode above the current one.
  always_comb begin
    first_sel = '0;
    first_any = 1'b0;
    next_sel  = '0;
    next_any  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (sel_mask[i]) begin
        first_sel = 3'(i);
        first_any = 1'b1;
      end
      if (mask[i] && (i > int'(op_sel))) begin
        next_sel = 3'(i);
        next_any = 1'b1;
      end
    end
  end

  // Sweep FSM: walks opcode / a / b, waits out the pipeline, pulses done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mask      <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_sel    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mask <= sel_mask;
            if (first_any) begin
              state  <= ISSUE;
              busy   <= 1'b1;
              op_sel <= first_sel;
              op_a   <= '0;
              op_b   <= '0;
            end else begin
              // empty mask: nothing to issue, report completion next cycle
              state <= FINISH;
              done  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (op_b != 4'hF) begin
            op_b <= op_b + 4'd1;
          end else if (op_a != 4'hF) begin
            op_a <= op_a + 4'd1;
            op_b <= '0;
          end else if (next_any) begin
            op_sel <= next_sel;
            op_a   <= '0;
            op_b   <= '0;
          end else begin
            state     <= DRAIN;
            op_sel    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (drain_cnt == 3'(LATENCY - 1)) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Head of the valid pipeline: a vector is live whenever we are in ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe_vld[0] <= 1'b0;
    else     pipe_vld[0] <= (state == ISSUE);
  end

  generate
    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_vld
      // Delay stage gi of the valid pipeline.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe_vld[gi] <= 1'b0;
        else     pipe_vld[gi] <= pipe_vld[gi-1];
      end
    end
  endgenerate

  // Fold each captured result into the signature; a new sweep clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
      count    <= '0;
    end else if (accept) begin
      checksum <= '0;
      count    <= '0;
    end else if (pipe_vld[LATENCY-1]) begin
      checksum <= {checksum[14:0], checksum[15]} ^ {8'h00, result};
      count    <= count + 12'd1;
    end
  end

`ifdef ALU_SWEEP_CHECK_EN
  logic [10:0] pipe_tag [LATENCY];
  logic [2:0]  t_sel;
  logic [3:0]  t_a;
  logic [3:0]  t_b;
  logic [7:0]  expected;
  logic        mismatch;

  // Head of the tag pipeline: the vector currently on op_*.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe_tag[0] <= '0;
    else     pipe_tag[0] <= {op_sel, op_a, op_b};
  end

  generate
    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_tag
      // Delay stage gi of the tag pipeline.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe_tag[gi] <= '0;
        else     pipe_tag[gi] <= pipe_tag[gi-1];
      end
    end
  endgenerate

  assign t_sel = pipe_tag[LATENCY-1][10:8];
  assign t_a   = pipe_tag[LATENCY-1][7:4];
  assign t_b   = pipe_tag[LATENCY-1][3:0];

  // Golden ALU result for the vector whose result is arriving now.
  always_comb begin
    expected = '0;
    case (t_sel)
      3'd0: expected = {4'h0, t_a} + {4'h0, t_b};
      3'd1: expected = {4'h0, t_a} - {4'h0, t_b};
      3'd2: expected = {4'h0, t_a & t_b};
      3'd3: expected = {4'h0, t_a | t_b};
      3'd4: expected = {4'h0, t_a ^ t_b};
      3'd5: expected = {~t_b, ~t_a};
      3'd6: expected = {4'h0, t_a} * {4'h0, t_b};
      default: expected = (t_b == 4'h0) ? 8'h00 : ({4'h0, t_a} / {4'h0, t_b});
    endcase
  end

  assign mismatch = pipe_vld[LATENCY-1] && (result != expected);

  // Saturating mismatch counter; the first mismatch of a sweep is latched
  // while err_cnt is still zero (it never returns to zero mid-sweep).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt  <= '0;
      fail_vec <= '0;
    end else if (accept) begin
      err_cnt  <= '0;
      fail_vec <= '0;
    end else if (mismatch) begin
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (err_cnt == 8'h00) fail_vec <= pipe_tag[LATENCY-1];
    end
  end
`else
  assign err_cnt  = '0;
  assign fail_vec = '0;
`endif

endmodule

// File: tb/tb_alu_sweep_seq.sv
// Self-checking bench for alu_sweep_seq: a 2-cycle reference ALU answers the
// sequencer; each sweep pushes its expected outcome into a scoreboard queue
// and a monitor pops and compares when the DUT pulses done.
module tb_alu_sweep_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  sel_mask;
  logic [7:0]  result;
  logic [3:0]  op_a;
  logic [3:0]  op_b;
  logic [2:0]  op_sel;
  logic        busy;
  logic        done;
  logic [15:0] checksum;
  logic [11:0] count;
  logic [7:0]  err_cnt;
  logic [10:0] fail_vec;

  alu_sweep_seq #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst), .start(start), .sel_mask(sel_mask), .result(result),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .busy(busy), .done(done),
    .checksum(checksum), .count(count), .err_cnt(err_cnt), .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;

  int pc = 0;
  always @(posedge clk) pc <= pc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    string       name;
    int          done_pc;
    int          busy_cycles;
    logic [11:0] cnt;
    logic [15:0] cs;
    logic [7:0]  ec;
    logic [10:0] fv;
  } exp_t;
  exp_t sb[$];

  // Reference ALU, two register stages; force_zero models a stuck result bus.
  bit force_zero = 1'b0;
  logic [7:0] alu_s1;

  function automatic logic [7:0] alu_ref(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (s)
      3'd0: r = ia + ib;
      3'd1: r = (ia - ib) & 255;
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = int'(~b) * 16 + int'(~a);
      3'd6: r = ia * ib;
      default: r = (ib == 0) ? 0 : ia / ib;
    endcase
    return r[7:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      alu_s1 <= '0;
      result <= '0;
    end else begin
      alu_s1 <= force_zero ? 8'h00 : alu_ref(op_sel, op_a, op_b);
      result <= alu_s1;
    end
  end

  function automatic logic [15:0] sweep_cs(input logic [7:0] m, input bit fz);
    logic [15:0] cs;
    logic [7:0]  r;
    cs = '0;
    for (int s = 0; s < 8; s++) begin
      if (m[s]) begin
        for (int a = 0; a < 16; a++) begin
          for (int b = 0; b < 16; b++) begin
            r  = fz ? 8'h00 : alu_ref(3'(s), 4'(a), 4'(b));
            cs = {cs[14:0], cs[15]} ^ {8'h00, r};
          end
        end
      end
    end
    return cs;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: tracks busy time and stray operand activity, checks on done.
  int busy_run = 0;
  int idle_op  = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_run = 0;
      idle_op  = 0;
    end else begin
      if (busy) busy_run++;
      if (!busy && ({op_sel, op_a, op_b} != 11'd0)) idle_op++;
      if (done) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_done: got done at pc %0d expected no done", pc);
        end else begin
          e = sb.pop_front();
          chk({e.name, " done_cycle"}, pc, e.done_pc);
          chk({e.name, " busy_cycles"}, busy_run, e.busy_cycles);
          chk({e.name, " idle_op_activity"}, idle_op, 0);
          chk({e.name, " busy_in_done"}, busy, 0);
          chk({e.name, " count"}, count, e.cnt);
          chk({e.name, " checksum"}, checksum, e.cs);
          chk({e.name, " err_cnt"}, err_cnt, e.ec);
          chk({e.name, " fail_vec"}, fail_vec, e.fv);
          $display("sweep %s: count=%0d checksum=%04h err_cnt=%0d fail_vec=%03h busy=%0d",
                   e.name, count, checksum, err_cnt, fail_vec, busy_run);
        end
        busy_run = 0;
        idle_op  = 0;
      end
    end
  end

  int acc_pc;

  // Issue a start and push the expected outcome; returns in cycle 1.
  task automatic start_sweep(input string nm, input logic [7:0] m, input bit fz,
                             input logic [7:0] ec_on, input logic [10:0] fv_on);
    exp_t e;
    int   n;
    @(negedge clk);
    n = $countones(m);
    e.name        = nm;
    e.done_pc     = pc + ((n == 0) ? 1 : 256 * n + 3);
    e.busy_cycles = (n == 0) ? 0 : 256 * n + 2;
    e.cnt         = 12'(256 * n);
    e.cs          = sweep_cs(m, fz);
`ifdef ALU_SWEEP_CHECK_EN
    e.ec = ec_on;
    e.fv = fv_on;
`else
    e.ec = 8'h00;
    e.fv = 11'h000;
    if (ec_on != 8'h00 || fv_on != 11'h000) e.ec = 8'h00;
`endif
    sb.push_back(e);
    force_zero = fz;
    sel_mask   = m;
    start      = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    acc_pc = pc;
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while (sb.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    sel_mask = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset ops", {op_sel, op_a, op_b}, 0);
    chk("reset count", count, 0);
    chk("reset checksum", checksum, 0);
    chk("reset err_cnt", err_cnt, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single opcode, correct ALU
    start_sweep("mask01", 8'h01, 1'b0, 8'd0, 11'h000);
    wait_drain(400);

    // empty mask
    start_sweep("mask00", 8'h00, 1'b0, 8'd0, 11'h000);
    wait_drain(20);

    // divide only, result stuck at zero
    start_sweep("mask80_zero", 8'h80, 1'b1, 8'd120, {3'b111, 4'd1, 4'd1});
    wait_drain(400);
    force_zero = 1'b0;

    // all opcodes: op_sel steps every 256 cycles
    start_sweep("maskFF", 8'hFF, 1'b0, 8'd0, 11'h000);
    for (int k = 0; k < 8; k++) begin
      while (pc < acc_pc + 256 * k) @(negedge clk);
      chk($sformatf("maskFF op_sel step%0d", k), op_sel, k);
      chk($sformatf("maskFF op_ab step%0d", k), {op_a, op_b}, 0);
    end
    wait_drain(2200);

    // start pulsed again in cycle 10 must be ignored
    start_sweep("mask01_restart", 8'h01, 1'b0, 8'd0, 11'h000);
    while (pc < acc_pc + 9) @(negedge clk);
    sel_mask = 8'hFF;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(400);
    repeat (20) @(negedge clk);

    // reset in ISSUE cycle 100 aborts the sweep
    @(negedge clk);
    sel_mask = 8'h01;
    start    = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    acc_pc = pc;
    while (pc < acc_pc + 99) @(negedge clk);
    chk("pre_reset busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midreset busy", busy, 0);
    chk("midreset ops", {op_sel, op_a, op_b}, 0);
    chk("midreset count", count, 0);
    chk("midreset checksum", checksum, 0);
    chk("midreset done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    start_sweep("after_reset", 8'h01, 1'b0, 8'd0, 11'h000);
    wait_drain(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
